csa_bulk_dispatcher: RTL and testbench

Round-robin scheduler between the 40-bit CSA input buffer and a bank of CSA channel engines. When the buffer signals at least one whole bulk and a channel is free, it reads exactly `BULK_WORDS` words back-to-back. It forwards them with start/end markers to one channel chosen by rotating priority. It sits directly downstream of the 32→40 width converter's read port. It is the only block that drives that port's read enable.

---
 rtl/csa_bulk_dispatcher.sv | 189 ++++++++++++++++++
 tb/tb_csa_bulk_dispatcher.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_bulk_dispatcher.sv
// csa_bulk_dispatcher
//
// Moves whole bulks of BULK_WORDS words from the 40-bit CSA input buffer
// (read port of the 32->40 width converter) to one of NUM_CH channel engines.
// A bulk starts only when the buffer holds a full bulk and some channel can
// take one. The target channel is picked by rotating priority. Once started,
// a bulk is always read and forwarded in full; only reset can cut it short.
//
// Ports
//   clk, rst_n      : clock, synchronous active-low reset
//   enable          : allows new bulks to start
//   src_r_ready     : source holds at least BULK_WORDS words
//   src_ren         : source read strobe (one word per high cycle)
//   src_rdata       : source data, valid the cycle after src_ren
//   ch_ready        : per-channel "can accept a full bulk"
//   ch_wen          : one-hot channel write strobe
//   ch_wdata        : channel write data (holds last value between bulks)
//   ch_sof, ch_eof  : first / last word of the bulk, qualified by ch_wen
//   busy            : FSM not idle
//   bulk_count      : bulks fully dispatched, wraps at 2^32
module csa_bulk_dispatcher #(
  parameter int DATA_WIDTH = 40,
  parameter int NUM_CH     = 4,
  parameter int BULK_WORDS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  src_r_ready,
  output logic                  src_ren,
  input  logic [DATA_WIDTH-1:0] src_rdata,
  input  logic [NUM_CH-1:0]     ch_ready,
  output logic [NUM_CH-1:0]     ch_wen,
  output logic [DATA_WIDTH-1:0] ch_wdata,
  output logic                  ch_sof,
  output logic                  ch_eof,
  output logic                  busy,
  output logic [31:0]           bulk_count
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // wcnt counts read words (0..BULK_WORDS-1) and the two drain cycles (0..1)
  localparam int CW = (BULK_WORDS > 2) ? $clog2(BULK_WORDS) : 1;
  localparam logic [CW-1:0] LAST_W  = CW'(BULK_WORDS - 1);
  localparam logic [PW-1:0] LAST_CH = PW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   ptr, ptr_nx;
  logic [PW-1:0]   sel, sel_nx;
  logic [CW-1:0]   wcnt, wcnt_nx;
  logic            src_ren_nx;
  logic            bulk_done;

  logic            rd_valid;
  logic            sof_p1;
  logic            eof_p1;

  // Wrapping increment of a channel index (NUM_CH need not be a power of 2).
  function automatic logic [PW-1:0] next_ch(input logic [PW-1:0] c);
    return (c == LAST_CH) ? '0 : c + PW'(1);
  endfunction

  // First ready channel scanning base, base+1, ... with wraparound.
  function automatic logic [PW-1:0] rr_pick(input logic [NUM_CH-1:0] rdy,
                                            input logic [PW-1:0]     base);
    logic [PW-1:0] pick;
    logic [PW-1:0] idx;
    logic          found;
    pick  = base;
    idx   = base;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && rdy[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = next_ch(idx);
    end
    return pick;
  endfunction

  function automatic logic [NUM_CH-1:0] onehot(input logic [PW-1:0] c);
    logic [NUM_CH-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    sel_nx     = sel;
    wcnt_nx    = wcnt;
    src_ren_nx = 1'b0;
    bulk_done  = 1'b0;
    case (state)
      IDLE: begin
        if (enable && src_r_ready && (|ch_ready)) begin
          sel_nx     = rr_pick(ch_ready, ptr);
          src_ren_nx = 1'b1;
          wcnt_nx    = '0;
          state_nx   = READ;
        end
      end
      READ: begin
        // src_ren is already high for word wcnt; keep it up until the last one
        if (wcnt == LAST_W) begin
          wcnt_nx  = '0;
          state_nx = DRAIN;
        end else begin
          wcnt_nx    = wcnt + CW'(1);
          src_ren_nx = 1'b1;
        end
      end
      DRAIN: begin
        // Two cycles: the read pipeline and the output register empty out
        if (wcnt == CW'(1)) begin
          wcnt_nx   = '0;
          ptr_nx    = next_ch(sel);
          bulk_done = 1'b1;
          state_nx  = IDLE;
        end else begin
          wcnt_nx = wcnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      sel        <= '0;
      wcnt       <= '0;
      src_ren    <= 1'b0;
      bulk_count <= '0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      sel     <= sel_nx;
      wcnt    <= wcnt_nx;
      src_ren <= src_ren_nx;
      if (bulk_done) begin
        bulk_count <= bulk_count + 32'd1;
      end
    end
  end

  assign busy = (state != IDLE);

  // Stage p1: source read issued last cycle, data arrives this cycle.
  // src_ren is high exactly while in READ, so wcnt is the word index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      sof_p1   <= 1'b0;
      eof_p1   <= 1'b0;
    end else begin
      rd_valid <= src_ren;
      sof_p1   <= src_ren && (wcnt == '0);
      eof_p1   <= src_ren && (wcnt == LAST_W);
    end
  end

  // Stage p2: register the word towards the latched channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_wen   <= '0;
      ch_wdata <= '0;
      ch_sof   <= 1'b0;
      ch_eof   <= 1'b0;
    end else begin
      ch_wen <= rd_valid ? onehot(sel) : '0;
      ch_sof <= rd_valid && sof_p1;
      ch_eof <= rd_valid && eof_p1;
      if (rd_valid) begin
        ch_wdata <= src_rdata;
      end
    end
  end

endmodule

// File: tb/tb_csa_bulk_dispatcher.sv
// Bench for csa_bulk_dispatcher: directed scenarios plus a randomized phase,
// checked against a bulk-level reference model (priority pointer, expected
// channel, word sequence from the source, bulk count, timing gaps).
module tb_csa_bulk_dispatcher;

  localparam int DW  = 40;
  localparam int NCH = 4;
  localparam int BW  = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic            src_r_ready;
  logic            src_ren;
  logic [DW-1:0]   src_rdata = '0;
  logic [NCH-1:0]  ch_ready;
  logic [NCH-1:0]  ch_wen;
  logic [DW-1:0]   ch_wdata;
  logic            ch_sof;
  logic            ch_eof;
  logic            busy;
  logic [31:0]     bulk_count;

  always #5 clk = ~clk;

  csa_bulk_dispatcher #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NCH),
    .BULK_WORDS (BW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .src_r_ready (src_r_ready),
    .src_ren     (src_ren),
    .src_rdata   (src_rdata),
    .ch_ready    (ch_ready),
    .ch_wen      (ch_wen),
    .ch_wdata    (ch_wdata),
    .ch_sof      (ch_sof),
    .ch_eof      (ch_eof),
    .busy        (busy),
    .bulk_count  (bulk_count)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Source buffer: returns words[] in order, one per src_ren cycle, next cycle.
  logic [DW-1:0] words [0:255];
  int src_idx = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      src_idx <= 0;
    end else if (src_ren) begin
      src_rdata <= words[src_idx[7:0]];
      src_idx   <= src_idx + 1;
    end
  end

  // Output monitor.
  typedef struct {
    int            cyc;
    logic [NCH-1:0] wen;
    logic [DW-1:0] d;
    logic          sof;
    logic          eof;
  } beat_t;

  beat_t beats[$];
  int    ren_starts[$];
  logic  prev_ren = 1'b0;
  int    busy_cyc = 0;
  int    bad_marks = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      beats.delete();
      ren_starts.delete();
      prev_ren = 1'b0;
    end else begin
      beat_t b;
      if (src_ren && !prev_ren) ren_starts.push_back(cyc);
      prev_ren = src_ren;
      if (ch_wen != '0) begin
        b.cyc = cyc; b.wen = ch_wen; b.d = ch_wdata; b.sof = ch_sof; b.eof = ch_eof;
        beats.push_back(b);
      end else if (ch_sof || ch_eof) begin
        bad_marks++;
      end
      if (busy) busy_cyc++;
    end
  end

  // Checking and reference model.
  int n_chk = 0;
  int n_err = 0;

  int            m_ptr, m_cnt, m_idx, rd, rs, last_start;
  logic [DW-1:0] last_word;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int p, input logic [NCH-1:0] m);
    logic [NCH-1:0] sh;
    for (int k = 0; k < NCH; k++) begin
      sh = m >> ((p + k) % NCH);
      if (sh[0]) return (p + k) % NCH;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_idx = 0; rd = 0; rs = 0;
    last_start = -1; last_word = '0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_start(input string tag);
    for (int t = 0; t < 30; t++) begin
      @(posedge clk); #1;
      if (src_ren) break;
    end
    chk({tag, ".start"}, 64'(src_ren), 64'd1);
  endtask

  task automatic check_bulk(input string tag, input logic [NCH-1:0] mask, input int exp_gap);
    int ch;
    int t;
    logic [NCH-1:0] exp_wen;
    ch = pick(m_ptr, mask);
    exp_wen = NCH'(1) << ch;
    t = 0;
    while ((beats.size() < rd + BW || ren_starts.size() <= rs) && t < 60) begin
      @(posedge clk);
      t++;
    end
    chk({tag, ".arrived"}, 64'(beats.size() >= rd + BW && ren_starts.size() > rs), 64'd1);
    if (beats.size() >= rd + BW && ren_starts.size() > rs) begin
      chk({tag, ".latency"}, 64'(beats[rd].cyc - ren_starts[rs]), 64'd2);
      if (exp_gap > 0 && last_start >= 0)
        chk({tag, ".gap"}, 64'(ren_starts[rs] - last_start), 64'(exp_gap));
      last_start = ren_starts[rs];
      rs++;
      for (int k = 0; k < BW; k++) begin
        chk($sformatf("%s.w%0d.wen", tag, k), 64'(beats[rd+k].wen), 64'(exp_wen));
        chk($sformatf("%s.w%0d.data", tag, k), 64'(beats[rd+k].d), 64'(words[m_idx+k]));
        chk($sformatf("%s.w%0d.sof", tag, k), 64'(beats[rd+k].sof), 64'(k == 0));
        chk($sformatf("%s.w%0d.eof", tag, k), 64'(beats[rd+k].eof), 64'(k == BW - 1));
        chk($sformatf("%s.w%0d.cyc", tag, k), 64'(beats[rd+k].cyc - beats[rd].cyc), 64'(k));
      end
      last_word = words[m_idx+BW-1];
      rd    += BW;
      m_idx += BW;
      m_ptr  = (ch + 1) % NCH;
      m_cnt++;
    end
  endtask

  task automatic check_idle(input string tag);
    for (int t = 0; t < 30; t++) begin
      @(posedge clk); #1;
      if (!busy) break;
    end
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".count"}, 64'(bulk_count), 64'(m_cnt));
    chk({tag, ".hold"}, 64'(ch_wdata), 64'(last_word));
  endtask

  // One bulk to the channel chosen from mask; inputs scrambled after the start.
  task automatic start_one(input string tag, input logic [NCH-1:0] mask);
    enable = 1'b1; src_r_ready = 1'b1; ch_ready = mask;
    wait_start(tag);
    src_r_ready = 1'b0;
    enable      = 1'($urandom_range(0, 1));
    ch_ready    = NCH'($urandom_range(0, 15));
    check_bulk(tag, mask, 0);
    check_idle(tag);
  endtask

  task automatic check_quiet(input string tag);
    int s0, b0;
    s0 = ren_starts.size();
    b0 = busy_cyc;
    repeat (20) @(posedge clk);
    #1;
    chk({tag, ".no_ren"}, 64'(ren_starts.size() - s0), 64'd0);
    chk({tag, ".no_busy"}, 64'(busy_cyc - b0), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    logic [NCH-1:0] m;

    for (int i = 0; i < 256; i++) words[i] = {8'($urandom), $urandom};
    for (int i = 0; i < 5; i++) words[i] = DW'(i + 1);

    // Reset with all inputs active
    rst_n = 1'b0; enable = 1'b1; src_r_ready = 1'b1; ch_ready = 4'hF;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.src_ren", 64'(src_ren), 64'd0);
    chk("rst.ch_wen", 64'(ch_wen), 64'd0);
    chk("rst.ch_wdata", 64'(ch_wdata), 64'd0);
    chk("rst.sof_eof", 64'({ch_sof, ch_eof}), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.count", 64'(bulk_count), 64'd0);
    b0 = busy_cyc;
    rst_n = 1'b1;
    #1;
    chk("rst.release_ren", 64'(src_ren), 64'd0);
    @(posedge clk); #1;
    chk("single.ren_after_edge", 64'(src_ren), 64'd1);
    src_r_ready = 1'b0;

    // Single bulk: words 1..5 to channel 0
    check_bulk("single", 4'hF, 0);
    check_idle("single");
    chk("single.busy_len", 64'(busy_cyc - b0), 64'(BW + 2));

    // Gating: each start condition alone blocks
    enable = 1'b0; src_r_ready = 1'b1; ch_ready = 4'hF;
    check_quiet("gate_en");
    enable = 1'b1; src_r_ready = 1'b0; ch_ready = 4'hF;
    check_quiet("gate_src");
    enable = 1'b1; src_r_ready = 1'b1; ch_ready = 4'h0;
    check_quiet("gate_ch");

    // Dropping enable and ch_ready mid-bulk
    enable = 1'b1; src_r_ready = 1'b1; ch_ready = 4'hF;
    wait_start("midgate");
    @(posedge clk); #1;
    enable = 1'b0; ch_ready = 4'h0; src_r_ready = 1'b0;
    check_bulk("midgate", 4'hF, 0);
    check_idle("midgate");

    // Round robin, back-to-back bulks from ptr 0
    enable = 1'b0; src_r_ready = 1'b0;
    do_reset(2);
    enable = 1'b1; src_r_ready = 1'b1; ch_ready = 4'hF;
    for (int i = 0; i < 5; i++) check_bulk($sformatf("rr%0d", i), 4'hF, 8);
    #1;
    enable = 1'b0; src_r_ready = 1'b0;
    check_idle("rr");

    // Skip busy channels
    do_reset(2);
    start_one("skip2", 4'b0100);
    start_one("skip0", 4'b0011);

    // Randomized masks
    for (int i = 0; i < 12; i++) begin
      m = NCH'($urandom_range(1, 15));
      start_one($sformatf("rand%0d", i), m);
    end

    // Reset in the middle of a bulk
    enable = 1'b0; src_r_ready = 1'b0;
    do_reset(2);
    enable = 1'b1; src_r_ready = 1'b1; ch_ready = 4'b0100;
    wait_start("midrst");
    src_r_ready = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(posedge clk); #1;
      if (beats.size() >= 2) break;
    end
    chk("midrst.two_words", 64'(beats.size() >= 2), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst.src_ren", 64'(src_ren), 64'd0);
    chk("midrst.ch_wen", 64'(ch_wen), 64'd0);
    chk("midrst.ch_wdata", 64'(ch_wdata), 64'd0);
    chk("midrst.sof_eof", 64'({ch_sof, ch_eof}), 64'd0);
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.count", 64'(bulk_count), 64'(m_cnt));
    rst_n = 1'b1;
    model_reset();
    start_one("after_rst", 4'hF);

    chk("stray_markers", 64'(bad_marks), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
